// File: rtl/mult_accumulator.sv
// Accumulates multiplier products into dot-product sums, tracking valid/last tags alongside the multiplier pipeline.
// Optional ACC_SATURATE_EN: clamp overflowing sums to all ones instead of wrapping.
module mult_accumulator #(
   parameter int WIDTH     = 48,
   parameter int LATENCY   = 2,
   parameter int GUARD     = 8,
   parameter int OUT_DEPTH = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        issue_valid,
   input  logic                        issue_last,
   input  logic [2*WIDTH-1:0]          prod,
   output logic                        stall,
   output logic [2*WIDTH+GUARD-1:0]    acc_out,
   output logic                        acc_ovf,
   output logic                        acc_valid,
   input  logic                        acc_ready,
   output logic                        busy,
   output logic                        proto_err
);

   localparam int ACC_W = 2*WIDTH + GUARD;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   logic [LATENCY-1:0] vld_line, last_line;
   logic               tail_vld, tail_last;
   logic [ACC_W-1:0]   acc;
   logic               ovf_run, first;

   logic [ACC_W-1:0]   fifo_sum [OUT_DEPTH];
   logic               fifo_ovf [OUT_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;

   logic [ACC_W-1:0]   base, sum_nxt;
   logic [ACC_W:0]     ext;
   logic               ovf_nxt, push, pop, do_push;
   int                 lasts_in_line;

   function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] b,
                                              input logic [2*WIDTH-1:0] p);
      return {1'b0, b} + (ACC_W+1)'(p);
   endfunction

`ifdef ACC_SATURATE_EN
   function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] s, input logic ovf);
      return ovf ? {ACC_W{1'b1}} : s;
   endfunction
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == OUT_DEPTH-1) ? '0 : p + PTR_W'(1);
   endfunction

   assign tail_vld  = vld_line[LATENCY-1];
   assign tail_last = last_line[LATENCY-1];

   always_comb begin
      base    = first ? '0 : acc;
      ext     = add_ext(base, prod);
      ovf_nxt = (~first & ovf_run) | ext[ACC_W];
`ifdef ACC_SATURATE_EN
      sum_nxt = saturate(ext[ACC_W-1:0], ovf_nxt);
`else
      sum_nxt = ext[ACC_W-1:0];
`endif
   end

   // Reserve a FIFO slot for every last still travelling through the tag line.
   always_comb begin
      lasts_in_line = 0;
      for (int i = 0; i < LATENCY; i++)
         lasts_in_line += int'(vld_line[i] & last_line[i]);
   end

   assign stall     = (int'(count) + lasts_in_line) >= (OUT_DEPTH - 1);
   assign acc_valid = (count != '0);
   assign pop       = acc_valid & acc_ready;
   assign push      = tail_vld & tail_last;
   assign do_push   = push & ((count < CNT_W'(OUT_DEPTH)) | pop);
   assign acc_out   = acc_valid ? fifo_sum[rd_ptr] : '0;
   assign acc_ovf   = acc_valid & fifo_ovf[rd_ptr];
   assign busy      = (|vld_line) | ~first;

   // Stage: tag line and accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_line  <= '0;
         last_line <= '0;
         acc       <= '0;
         ovf_run   <= 1'b0;
         first     <= 1'b1;
         proto_err <= 1'b0;
      end else begin
         vld_line[0]  <= issue_valid & ~stall;
         last_line[0] <= issue_last;
         for (int i = 1; i < LATENCY; i++) begin
            vld_line[i]  <= vld_line[i-1];
            last_line[i] <= last_line[i-1];
         end
         if (issue_valid && stall)
            proto_err <= 1'b1;
         if (tail_vld) begin
            if (tail_last) begin
               acc     <= '0;
               ovf_run <= 1'b0;
               first   <= 1'b1;
            end else begin
               acc     <= sum_nxt;
               ovf_run <= ovf_nxt;
               first   <= 1'b0;
            end
         end
      end
   end

   // Stage: output FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            fifo_sum[i] <= '0;
            fifo_ovf[i] <= 1'b0;
         end
      end else begin
         if (do_push) begin
            fifo_sum[wr_ptr] <= sum_nxt;
            fifo_ovf[wr_ptr] <= ovf_nxt;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator; models a 2-cycle multiplier feeding prod.
module tb_mult_accumulator;

   localparam int WIDTH = 48;
   localparam int GUARD = 1;
   localparam int ACC_W = 2*WIDTH + GUARD;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               issue_valid = 1'b0, issue_last = 1'b0;
   logic [WIDTH-1:0]   a = '0, b = '0;
   logic [2*WIDTH-1:0] m1, prod;
   logic               stall, acc_ovf, acc_valid, busy, proto_err;
   logic               acc_ready = 1'b0;
   logic [ACC_W-1:0]   acc_out;
   logic [ACC_W-1:0]   exp_big;
   logic [WIDTH-1:0]   all1;
   int                 tests = 0, failed = 0, n_issued;

   mult_accumulator #(.WIDTH(WIDTH), .LATENCY(2), .GUARD(GUARD), .OUT_DEPTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_last(issue_last),
      .prod(prod), .stall(stall), .acc_out(acc_out), .acc_ovf(acc_ovf),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      m1   <= a * b;
      prod <= m1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic l, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      issue_valid = v;
      issue_last  = l;
      a = x;
      b = y;
      tick();
      issue_valid = 1'b0;
      issue_last  = 1'b0;
      a = 48'd7;
      b = 48'd7;
   endtask

   task automatic expect_res(input string tag, input logic [ACC_W-1:0] ev, input logic eo);
      int n;
      n = 0;
      acc_ready = 1'b1;
      while (acc_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, acc_valid, 1);
      chk(tag, acc_out, ev);
      chk({tag, "_ovf"}, acc_ovf, eo);
      tick();
   endtask

   initial begin
      // 1: asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_valid", acc_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_proto", proto_err, 0);
      chk("rst_out", acc_out, 0);
      chk("rst_ovf", acc_ovf, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 2: single term 3*5, valid three cycles after issue
      acc_ready = 1'b1;
      drive(1, 1, 3, 5);
      chk("lat_t1", acc_valid, 0);
      chk("busy_t1", busy, 1);
      tick();
      chk("lat_t2", acc_valid, 0);
      tick();
      chk("lat_t3", acc_valid, 1);
      chk("single_out", acc_out, 15);
      chk("single_ovf", acc_ovf, 0);
      tick();
      chk("single_pop", acc_valid, 0);

      // 3: four-term dot then a one-term dot back to back
      drive(1, 0, 1, 2);
      drive(1, 0, 3, 4);
      drive(1, 0, 5, 6);
      drive(1, 1, 7, 8);
      drive(1, 1, 2, 2);
      expect_res("dot100", 100, 0);
      expect_res("dot4", 4, 0);
      chk("dot_empty", acc_valid, 0);

      // 4: consumer blocked, issue until stall rises
      acc_ready = 1'b0;
      n_issued = 0;
      for (int n = 3; n <= 5; n++) begin
         if (stall) break;
         drive(1, 1, 48'(n), 48'(n));
         n_issued++;
      end
      chk("fill_issued", n_issued, 2);
      chk("fill_stall", stall, 1);
      repeat (4) tick();
      chk("fill_hold_stall", stall, 1);
      chk("fill_head", acc_out, 9);
      chk("fill_proto", proto_err, 0);
      expect_res("drain9", 9, 0);
      expect_res("drain16", 16, 0);
      chk("drain_empty", acc_valid, 0);
      chk("drain_stall", stall, 0);
      drive(1, 1, 5, 5);
      expect_res("drain25", 25, 0);

      // 5: overflow of 97-bit accumulator
      all1 = '1;
      drive(1, 0, all1, all1);
      drive(1, 0, all1, all1);
      drive(1, 1, all1, all1);
`ifdef ACC_SATURATE_EN
      exp_big = '1;
`else
      exp_big = (97'd1 << 96) - (97'd3 << 49) + 97'd3;
`endif
      expect_res("ovf_sum", exp_big, 1);
      drive(1, 1, 2, 3);
      expect_res("after_ovf", 6, 0);

      // 6: reset mid-dot, then protocol violation during stall
      drive(1, 0, 9, 9);
      drive(1, 0, 9, 9);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      drive(1, 1, 4, 4);
      expect_res("post_rst", 16, 0);
      chk("post_rst_empty", acc_valid, 0);

      acc_ready = 1'b0;
      drive(1, 1, 2, 2);
      drive(1, 1, 3, 3);
      chk("pe_stall", stall, 1);
      drive(1, 1, 6, 6);
      chk("pe_sticky", proto_err, 1);
      repeat (4) tick();
      expect_res("pe_r4", 4, 0);
      expect_res("pe_r9", 9, 0);
      tick();
      chk("pe_dropped", acc_valid, 0);
      chk("pe_still", proto_err, 1);
      chk("idle_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
